bram_axis_reader: RTL
=====================

BRAM_AXIS_READER -- requirements
Module: bram_axis_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, BRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, BRAM word and stream data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request to read one BRAM region; sampled only in IDLE.
REQ-006 SHALL have port index_cntl  input  ADDR_W  first word address of the region; latched on an accepted start.
REQ-007 SHALL have port size_cntl  input  ADDR_W  last word address of the region, inclusive; latched on an accepted start.
REQ-008 SHALL have port bram_en  output  1  BRAM read enable.
REQ-009 SHALL have port bram_index  output  ADDR_W  BRAM read address.
REQ-010 SHALL have port bram_dout  input  DATA_W  BRAM read data; valid one cycle after bram_en.
REQ-011 SHALL have port m_axis_tdata  output  DATA_W  stream data.
REQ-012 SHALL have port m_axis_tvalid  output  1  stream valid.
REQ-013 SHALL have port m_axis_tready  input  1  stream ready from the sink.
REQ-014 SHALL have port m_axis_tlast  output  1  marks the final word of the region.
REQ-015 SHALL have port busy  output  1  high while a region transfer is in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a region transfer completes.

Function
REQ-017 SHALL use three states: IDLE, READ (BRAM reads outstanding), DRAIN (all reads issued, buffer not empty).
REQ-018 SHALL accept start only in IDLE; start while busy is ignored and SHALL NOT alter the latched region.
REQ-019 SHALL compute region length as ((size_cntl - index_cntl) mod 2^ADDR_W) + 1, giving 1 to 2^ADDR_W words; size_cntl < index_cntl wraps past 2^ADDR_W-1 to 0.
REQ-020 SHALL, on a start accepted in cycle N, drive bram_en=1 with bram_index=index_cntl in cycle N+1, and busy=1 from cycle N+1.
REQ-021 SHALL increment bram_index by 1 modulo 2^ADDR_W per issued read, in order, with no address skipped or repeated.
REQ-022 SHALL capture bram_dout into a 2-entry output buffer at the end of the cycle following each bram_en=1 cycle; the first m_axis_tvalid is asserted in cycle N+3.
REQ-023 SHALL issue a read only when (buffer entries + reads in flight - handshake this cycle) < 2, so the buffer never overflows and no BRAM word is lost.
REQ-024 SHALL sustain one word per cycle while m_axis_tready is held high.
REQ-025 SHALL count a transfer only when m_axis_tvalid and m_axis_tready are both high at a rising edge.
REQ-026 SHALL hold m_axis_tdata and m_axis_tlast stable, and keep m_axis_tvalid high, while m_axis_tvalid=1 and m_axis_tready=0.
REQ-027 SHALL assert m_axis_tlast only together with the final word of the region; a 1-word region asserts it on its only word.
REQ-028 SHALL move READ->DRAIN after the final read is issued, and DRAIN->IDLE on the tlast handshake.
REQ-029 SHALL pulse done=1 and drop busy in the cycle after the tlast handshake; a start in that same cycle is accepted.
REQ-030 SHALL keep bram_en=0 in IDLE and DRAIN and whenever the buffer-credit rule blocks a read.

Reset
REQ-031 SHALL, while rstn=0 at a rising edge, force the state to IDLE, empty the buffer, discard reads in flight, and drive bram_en, bram_index, m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy and done to 0 from the next cycle.
REQ-032 SHALL treat a reset in the middle of a transfer identically; no partial word or tlast is emitted afterwards, and the next start behaves as from power-up.

Verification
REQ-033 Region 0..15, tready=1 -> addresses 0..15 issued on consecutive cycles; 16 words emitted in order, one per cycle from cycle N+3; tlast on word 16; done 1 cycle later.
REQ-034 Region 5..5 -> exactly one read at address 5; one word with tlast=1; done pulse.
REQ-035 Region 510..1 -> addresses 510,511,0,1 issued; 4 words emitted; tlast on the word read from address 1.
REQ-036 Region 0..15 with tready toggled randomly and held low for 5 cycles -> tdata/tlast stable during stalls; no word lost or duplicated; bram_en=0 while the buffer is full.
REQ-037 start pulsed again mid-transfer -> ignored; only the original 16 words are emitted.
REQ-038 rstn=0 after the 7th handshake of region 0..15 -> all outputs 0 the next cycle; a new start for region 3..4 yields exactly 2 words from addresses 3 and 4.

Source files
------------

// File: rtl/bram_axis_reader.sv
// Streams a contiguous (wrapping) BRAM word region out over AXI-Stream.
// Reads are credit-limited against a 2-entry output buffer so no word is ever dropped.
module bram_axis_reader #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] index_cntl,
    input  logic [ADDR_W-1:0] size_cntl,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_index,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                rd_vld_q, rd_vld_d;
    logic                rd_last_q, rd_last_d;
    logic                head_vld_q, head_vld_d;
    logic [DATA_W-1:0]   head_data_q, head_data_d;
    logic                head_last_q, head_last_d;
    logic                skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                skid_last_q, skid_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                hs;
    logic [1:0]          occ;
    logic                rd_issue;

    // Credit: words buffered plus the read whose data lands this cycle, minus the one leaving.
    assign hs       = head_vld_q & m_axis_tready;
    assign occ      = 2'(head_vld_q) + 2'(skid_vld_q) + 2'(rd_vld_q) - 2'(hs);
    assign rd_issue = (state_q == READ) && (occ < 2'd2);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_vld_d    = rd_issue;
        rd_last_d   = rd_issue && (rem_q == CNT_W'(1));
        head_vld_d  = head_vld_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;

        // Pop advances the skid entry into the output slot; returning data fills the first free slot.
        if (hs) begin
            head_vld_d  = skid_vld_q;
            head_data_d = skid_data_q;
            head_last_d = skid_last_q;
            skid_vld_d  = 1'b0;
        end
        if (rd_vld_q) begin
            if (!head_vld_d) begin
                head_vld_d  = 1'b1;
                head_data_d = bram_dout;
                head_last_d = rd_last_q;
            end else begin
                skid_vld_d  = 1'b1;
                skid_data_d = bram_dout;
                skid_last_d = rd_last_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    addr_d  = index_cntl;
                    rem_d   = CNT_W'(ADDR_W'(size_cntl - index_cntl)) + CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            READ: begin
                if (rd_issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs && head_last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            head_vld_q  <= 1'b0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            head_vld_q  <= head_vld_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bram_en       = rd_issue;
    assign bram_index    = addr_q;
    assign m_axis_tdata  = head_data_q;
    assign m_axis_tvalid = head_vld_q;
    assign m_axis_tlast  = head_last_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
